ssp_adj_packer: RTL and testbench
=================================

Name: ssp_adj_packer

Overview:
Feeder for the SSSP accelerator. It takes a stream of adjacency edges (source node, neighbour, weight) from the DRAM edge reader. It packs up to 15 edges per node into the 1024-bit adjacency beat that the accelerator consumes. Nodes with more than 15 edges are split across beats, with a tail flag that tells the accelerator another beat for the same node follows.

Parameters:
MAX_EDGES, 15, edge slots per beat; fixed by beat layout, legal range 1..15
INF_ID, 32'hFFFF_FFFF, neighbour id written into unused slots

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_valid  in  1  edge word valid
s_ready  out  1  packer accepts edge word
s_node  in  32  source node id of edge
s_nbr  in  32  neighbour node id
s_wt  in  32  edge weight
s_last  in  1  last edge of s_node
s_empty  in  1  s_node has no edges; s_nbr/s_wt ignored; must come with s_last=1
m_valid  out  1  adjacency beat valid
m_ready  in  1  accelerator accepts beat
m_data  out  1024  adjacency beat
beats_sent  out  16  count of beats handshaken, wraps
nodes_done  out  16  count of beats with tail=0 handshaken, wraps
err  out  1  sticky protocol error

Behaviour:
- Reset (rstn=0 at clk edge), synchronous, takes priority over everything:
  - state=FILL, slot=0, m_valid=0, m_data=0, beats_sent=0, nodes_done=0, err=0, cont=0.
  - Reset mid-beat drops the partial or pending beat silently.
- Beat layout:
  - m_data[31:0] = node id.
  - For k=1..15: m_data[64k-32 +: 32] = neighbour, m_data[64k +: 32] = weight.
  - m_data[992] = tail (1 = more edges of this node follow).
  - m_data[996:993] = edge count (0..15).
  - m_data[1023:997] = 0.
  - Unused slots: neighbour = INF_ID, weight = 0.
- States:
  - FILL: s_ready=1, m_valid=0.
  - EMIT: s_ready=0, m_valid=1, m_data stable until handshake.
- FILL, edge accepted (s_valid & s_ready), normal edge:
  - When slot==0 and cont==0, latch node id from s_node.
  - Write s_nbr/s_wt into slot+1, then slot++.
  - Go to EMIT when the new slot==MAX_EDGES or s_last=1.
  - tail = ~s_last. Count = number of filled slots.
- FILL, accepted edge with s_empty=1 and slot==0:
  - Beat has count=0, tail=0, all slots INF_ID/0; go to EMIT.
- Latency: m_valid rises the cycle after the completing edge is accepted. Throughput is one edge per cycle in FILL, plus at least one EMIT cycle per beat.
- EMIT, handshake (m_valid & m_ready):
  - beats_sent++. If tail=0, nodes_done++.
  - slot=0, all slots reset to INF_ID/0, state=FILL.
  - cont = tail. When cont=1 the node id is retained.
- Edges arriving during EMIT stall (s_ready=0); no edge is lost or duplicated.
- MAX_EDGES-th edge with s_last=1: single beat, tail=0, count=15. No empty follow-on beat.
- err is set (sticky until reset) when any of these is seen on an accepted edge:
  - s_node differs from the latched node id while slot>0 or cont=1;
  - s_empty=1 with slot>0, cont=1, or s_last=0.
  - An erroneous edge is still processed as a normal edge, except s_empty is then ignored.
- Counters wrap 16'hFFFF->0.

Test Plan:
- Reset, then node 5 with 3 edges (7,2),(9,4),(12,1), s_last on the third, m_ready=1 -> one beat:
  - [31:0]=5, slots 1..3 hold those edges, slots 4..15 = INF/0;
  - count=3, tail=0, m_valid at cycle after the third accept;
  - beats_sent=1, nodes_done=1.
- Node 8 with 20 edges, back-to-back -> two beats:
  - beat 1: count=15, tail=1, node=8;
  - beat 2: count=5, tail=0, node=8;
  - nodes_done increments once.
- Node 3 with exactly 15 edges -> single beat, count=15, tail=0, no second beat.
- s_empty node 4 -> beat with node=4, count=0, tail=0, all slots INF/0.
- Backpressure, m_ready=0 for 10 cycles during EMIT:
  - m_data stable, s_ready=0 throughout;
  - next edge is accepted only after the handshake;
  - the following beat is correct.
- Node id changes mid-node (edge 2 carries s_node=6 during node 5), and separately rstn=0 during EMIT:
  - first case: err=1 and stays set;
  - second case: m_valid=0 and counters=0 the next cycle, and the next node packs cleanly.

Source files
------------

// File: rtl/ssp_adj_packer.sv
// ssp_adj_packer: packs a stream of adjacency edges into 1024-bit adjacency
// beats for the SSSP accelerator. Up to MAX_EDGES edges of one source node go
// into one beat; nodes with more edges are split across beats, and the tail
// flag tells the accelerator that another beat for the same node follows.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   s_valid/s_ready        edge-word handshake from the DRAM edge reader
//   s_node/s_nbr/s_wt      source node id, neighbour id, edge weight
//   s_last                 last edge of s_node
//   s_empty                s_node has no edges (comes with s_last=1)
//   m_valid/m_ready        adjacency-beat handshake to the accelerator
//   m_data                 adjacency beat
//   beats_sent             beats handshaken (wraps)
//   nodes_done             beats with tail=0 handshaken (wraps)
//   err                    sticky protocol error
//
// Beat layout:
//   [31:0]            node id
//   [64k-32 +: 32]    neighbour of slot k (k=1..15), INF_ID when unused
//   [64k +: 32]       weight of slot k, 0 when unused
//   [992]             tail
//   [996:993]         edge count
//   [1023:997]        zero
module ssp_adj_packer #(
  parameter int unsigned MAX_EDGES = 15,
  parameter logic [31:0] INF_ID    = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_node,
  input  logic [31:0]   s_nbr,
  input  logic [31:0]   s_wt,
  input  logic          s_last,
  input  logic          s_empty,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [1023:0] m_data,
  output logic [15:0]   beats_sent,
  output logic [15:0]   nodes_done,
  output logic          err
);

  localparam int unsigned ID_W     = 32;
  localparam int unsigned BEAT_W   = 1024;
  localparam int unsigned SLOT_W   = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NSLOT    = 15;
  localparam int unsigned TAIL_BIT = 992;
  localparam int unsigned CNT_LSB  = 993;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                cont_q, cont_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [CNT_W-1:0]    nodes_q, nodes_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;

  logic [ID_W-1:0]     cur_node;
  logic [BEAT_W-1:0]   base;
  logic [SLOT_W-1:0]   slot_inc;
  logic                node_err;
  logic                empty_err;
  logic                empty_ok;

  // Beat with the given node id, every slot empty (INF_ID/0), count 0, tail 0.
  function automatic logic [BEAT_W-1:0] blank_beat(input logic [ID_W-1:0] node);
    logic [BEAT_W-1:0] b;
    b = '0;
    b[ID_W-1:0] = node;
    for (int unsigned k = 1; k <= NSLOT; k++) begin
      b[64*k-32 +: 32] = INF_ID;
    end
    return b;
  endfunction

  // Next-state logic for the FILL/EMIT packer.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    beat_d    = beat_q;
    cont_d    = cont_q;
    err_d     = err_q;
    beats_d   = beats_q;
    nodes_d   = nodes_q;
    cur_node  = beat_q[ID_W-1:0];
    base      = beat_q;
    slot_inc  = slot_q + SLOT_W'(1);
    node_err  = 1'b0;
    empty_err = 1'b0;
    empty_ok  = 1'b0;

    case (state_q)
      FILL: begin
        if (s_valid && s_ready_q) begin
          node_err  = ((slot_q != '0) || cont_q) && (s_node != cur_node);
          empty_err = s_empty && ((slot_q != '0) || cont_q || !s_last);
          // A malformed empty marker is treated as an ordinary edge.
          empty_ok  = s_empty && !empty_err;
          if (node_err || empty_err) begin
            err_d = 1'b1;
          end

          // First edge of a beat starts from a clean slot image; a continued
          // node keeps its id, a new node latches s_node.
          if (slot_q == '0) begin
            base = blank_beat(cont_q ? cur_node : s_node);
          end

          if (empty_ok) begin
            beat_d  = base;
            state_d = EMIT;
          end else begin
            beat_d = base;
            for (int unsigned k = 1; k <= NSLOT; k++) begin
              if (slot_inc == SLOT_W'(k)) begin
                beat_d[64*k-32 +: 32] = s_nbr;
                beat_d[64*k +: 32]    = s_wt;
              end
            end
            beat_d[TAIL_BIT]              = ~s_last;
            beat_d[CNT_LSB +: SLOT_W]     = slot_inc;
            slot_d                        = slot_inc;
            if ((slot_inc == SLOT_W'(MAX_EDGES)) || s_last) begin
              state_d = EMIT;
            end
          end
        end
      end

      EMIT: begin
        if (m_ready) begin
          beats_d = beats_q + CNT_W'(1);
          if (!beat_q[TAIL_BIT]) begin
            nodes_d = nodes_q + CNT_W'(1);
          end
          cont_d  = beat_q[TAIL_BIT];
          slot_d  = '0;
          beat_d  = blank_beat(cur_node);
          state_d = FILL;
        end
      end

      default: state_d = FILL;
    endcase

    s_ready_d = (state_d == FILL);
    m_valid_d = (state_d == EMIT);
  end

  // State and output registers; synchronous reset drops any partial beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= FILL;
      slot_q    <= '0;
      beat_q    <= '0;
      cont_q    <= 1'b0;
      err_q     <= 1'b0;
      beats_q   <= '0;
      nodes_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      beat_q    <= beat_d;
      cont_q    <= cont_d;
      err_q     <= err_d;
      beats_q   <= beats_d;
      nodes_q   <= nodes_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = beat_q;
  assign beats_sent = beats_q;
  assign nodes_done = nodes_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ssp_adj_packer.sv
// Bench for ssp_adj_packer: expected beats are built from the edge lists and
// queued at drive time; a monitor queues every handshaken beat, and the two
// queues are compared in order.
module tb_ssp_adj_packer;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_node;
  logic [31:0]   s_nbr;
  logic [31:0]   s_wt;
  logic          s_last;
  logic          s_empty;
  logic          m_valid;
  logic          m_ready;
  logic [1023:0] m_data;
  logic [15:0]   beats_sent;
  logic [15:0]   nodes_done;
  logic          err;

  always #5 clk = ~clk;

  ssp_adj_packer dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_node     (s_node),
    .s_nbr      (s_nbr),
    .s_wt       (s_wt),
    .s_last     (s_last),
    .s_empty    (s_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .beats_sent (beats_sent),
    .nodes_done (nodes_done),
    .err        (err)
  );

  int errors = 0;
  int checks = 0;

  logic [1023:0] exp_q[$];
  logic [1023:0] got_q[$];
  logic [15:0]   bs_snap[$];
  logic [15:0]   nd_snap[$];
  logic [15:0]   exp_beats = '0;
  logic [15:0]   exp_nodes = '0;

  typedef struct {
    logic [31:0] node;
    int          n;
    bit          empty;
    int          beats;
  } vec_t;

  // Record every handshaken beat and the counters seen just before it.
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      got_q.push_back(m_data);
      bs_snap.push_back(beats_sent);
      nd_snap.push_back(nodes_done);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic logic [31:0] wt_of(input logic [31:0] node, input int i);
    return 32'(node * 7 + 32'(i) * 3 + 1);
  endfunction

  function automatic logic [1023:0] mk_beat(input logic [31:0] node, input logic [31:0] nb[$],
                                            input logic [31:0] w[$], input int start,
                                            input int cnt, input bit tail);
    logic [1023:0] b;
    b = '0;
    b[31:0] = node;
    for (int k = 1; k <= 15; k++) begin
      if (k <= cnt) begin
        b[64*k-32 +: 32] = nb[start+k-1];
        b[64*k +: 32]    = w[start+k-1];
      end else begin
        b[64*k-32 +: 32] = 32'hFFFF_FFFF;
      end
    end
    b[992]     = tail;
    b[996:993] = 4'(cnt);
    return b;
  endfunction

  // Drive one edge word and hold it until it is accepted (bounded).
  task automatic send_edge(input logic [31:0] node, input logic [31:0] nbr, input logic [31:0] wt,
                           input logic last, input logic empty);
    int t = 0;
    s_valid = 1'b1;
    s_node  = node;
    s_nbr   = nbr;
    s_wt    = wt;
    s_last  = last;
    s_empty = empty;
    while (!s_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got s_ready=0 required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_empty = 1'b0;
  endtask

  // Queue the expected beats of one node, then send its edges.
  task automatic send_node(input logic [31:0] node, input int n, input bit empty);
    logic [31:0] nb[$];
    logic [31:0] w[$];
    int start;
    int cnt;
    for (int i = 0; i < n; i++) begin
      nb.push_back(32'(node * 1000 + 32'(i)));
      w.push_back(wt_of(node, i));
    end
    if (empty) begin
      exp_q.push_back(mk_beat(node, nb, w, 0, 0, 1'b0));
      send_edge(node, 32'h1234_5678, 32'h9abc_def0, 1'b1, 1'b1);
    end else begin
      start = 0;
      while (start < n) begin
        cnt = (n - start > 15) ? 15 : n - start;
        exp_q.push_back(mk_beat(node, nb, w, start, cnt, (start + cnt) < n));
        start += cnt;
      end
      for (int i = 0; i < n; i++) begin
        send_edge(node, nb[i], w[i], i == n - 1, 1'b0);
      end
    end
  endtask

  // Wait for outstanding beats, then compare observed against expected.
  task automatic drain(input string name);
    int t = 0;
    logic [1023:0] g;
    logic [1023:0] e;
    logic [15:0] bs;
    logic [15:0] nd;
    while ((got_q.size() < exp_q.size() || m_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g  = got_q.pop_front();
      e  = exp_q.pop_front();
      bs = bs_snap.pop_front();
      nd = nd_snap.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s beat: got node=%0h cnt=%0d tail=%0b s1=%0h/%0h required node=%0h cnt=%0d tail=%0b s1=%0h/%0h",
                 name, g[31:0], g[996:993], g[992], g[63:32], g[95:64],
                 e[31:0], e[996:993], e[992], e[63:32], e[95:64]);
      end
      chk({name, " beats_sent_pre"}, 64'(bs), 64'(exp_beats));
      chk({name, " nodes_done_pre"}, 64'(nd), 64'(exp_nodes));
      exp_beats = exp_beats + 16'd1;
      if (!e[992]) exp_nodes = exp_nodes + 16'd1;
    end
    chk({name, " extra_beats"}, 64'(got_q.size()), 64'd0);
    chk({name, " missing_beats"}, 64'(exp_q.size()), 64'd0);
    got_q.delete();
    exp_q.delete();
    bs_snap.delete();
    nd_snap.delete();
    chk({name, " beats_sent"}, 64'(beats_sent), 64'(exp_beats));
    chk({name, " nodes_done"}, 64'(nodes_done), 64'(exp_nodes));
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] nb[$];
    logic [31:0] w[$];
    logic [1023:0] held;
    logic [15:0] b0;
    logic [15:0] n0;

    vecs[0] = '{node: 32'd8,  n: 20, empty: 1'b0, beats: 2};
    vecs[1] = '{node: 32'd3,  n: 15, empty: 1'b0, beats: 1};
    vecs[2] = '{node: 32'd4,  n: 0,  empty: 1'b1, beats: 1};
    vecs[3] = '{node: 32'd11, n: 1,  empty: 1'b0, beats: 1};
    vecs[4] = '{node: 32'd12, n: 30, empty: 1'b0, beats: 2};
    vecs[5] = '{node: 32'd13, n: 16, empty: 1'b0, beats: 2};
    vecs[6] = '{node: 32'd14, n: 14, empty: 1'b0, beats: 1};

    rstn    = 1'b0;
    s_valid = 1'b0;
    s_node  = '0;
    s_nbr   = '0;
    s_wt    = '0;
    s_last  = 1'b0;
    s_empty = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst s_ready", 64'(s_ready), 64'd1);
    chk("rst m_data_lo", m_data[63:0], 64'd0);
    chk("rst beats_sent", 64'(beats_sent), 64'd0);
    chk("rst nodes_done", 64'(nodes_done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    rstn = 1'b1;

    // Node 5 with three explicit edges, latency of m_valid.
    nb = '{32'd7, 32'd9, 32'd12};
    w  = '{32'd2, 32'd4, 32'd1};
    exp_q.push_back(mk_beat(32'd5, nb, w, 0, 3, 1'b0));
    send_edge(32'd5, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("n5 m_valid_early", 64'(m_valid), 64'd0);
    send_edge(32'd5, 32'd9, 32'd4, 1'b0, 1'b0);
    send_edge(32'd5, 32'd12, 32'd1, 1'b1, 1'b0);
    chk("n5 m_valid_latency", 64'(m_valid), 64'd1);
    drain("n5");
    chk("n5 beats_sent", 64'(beats_sent), 64'd1);
    chk("n5 nodes_done", 64'(nodes_done), 64'd1);

    // Table of nodes with various edge counts.
    for (int v = 0; v < 7; v++) begin
      b0 = beats_sent;
      n0 = nodes_done;
      send_node(vecs[v].node, vecs[v].n, vecs[v].empty);
      drain($sformatf("vec%0d", v));
      chk($sformatf("vec%0d nbeats", v), 64'(16'(beats_sent - b0)), 64'(vecs[v].beats));
      chk($sformatf("vec%0d nnodes", v), 64'(16'(nodes_done - n0)), 64'd1);
      chk($sformatf("vec%0d err", v), 64'(err), 64'd0);
    end

    // Backpressure: beat held for 10 cycles while the next edge waits.
    m_ready = 1'b0;
    send_node(32'd20, 2, 1'b0);
    chk("bp m_valid", 64'(m_valid), 64'd1);
    held    = m_data;
    s_valid = 1'b1;
    s_node  = 32'd21;
    s_nbr   = 32'd21000;
    s_wt    = wt_of(32'd21, 0);
    s_last  = 1'b0;
    s_empty = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (m_data !== held) begin
        errors++;
        $display("FAIL bp m_data_stable cycle %0d: got node=%0h cnt=%0d required node=%0h cnt=%0d",
                 c, m_data[31:0], m_data[996:993], held[31:0], held[996:993]);
      end
      chk($sformatf("bp s_ready c%0d", c), 64'(s_ready), 64'd0);
      chk($sformatf("bp m_valid c%0d", c), 64'(m_valid), 64'd1);
    end
    m_ready = 1'b1;
    send_node(32'd21, 3, 1'b0);
    drain("bp");

    // Node id changes mid-node: err rises and stays.
    nb = '{32'd50, 32'd51, 32'd52};
    w  = '{32'd60, 32'd61, 32'd62};
    exp_q.push_back(mk_beat(32'd5, nb, w, 0, 3, 1'b0));
    send_edge(32'd5, 32'd50, 32'd60, 1'b0, 1'b0);
    chk("nerr before", 64'(err), 64'd0);
    send_edge(32'd6, 32'd51, 32'd61, 1'b0, 1'b0);
    chk("nerr set", 64'(err), 64'd1);
    send_edge(32'd5, 32'd52, 32'd62, 1'b1, 1'b0);
    drain("nerr");
    repeat (5) @(posedge clk);
    #1;
    chk("nerr sticky", 64'(err), 64'd1);

    // Reset while a beat is pending in EMIT.
    m_ready = 1'b0;
    send_edge(32'd40, 32'd1, 32'd2, 1'b1, 1'b0);
    chk("rstemit m_valid", 64'(m_valid), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_beats = '0;
    exp_nodes = '0;
    chk("rstemit m_valid_after", 64'(m_valid), 64'd0);
    chk("rstemit s_ready", 64'(s_ready), 64'd1);
    chk("rstemit beats_sent", 64'(beats_sent), 64'd0);
    chk("rstemit nodes_done", 64'(nodes_done), 64'd0);
    chk("rstemit err", 64'(err), 64'd0);
    chk("rstemit m_data_lo", m_data[63:0], 64'd0);
    m_ready = 1'b1;
    send_node(32'd41, 4, 1'b0);
    drain("rstemit");

    // Reset with a partial beat in FILL; the next node must start clean.
    send_edge(32'd42, 32'd77, 32'd88, 1'b0, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_beats = '0;
    exp_nodes = '0;
    send_node(32'd43, 1, 1'b0);
    drain("rstfill");

    // Empty marker arriving after an edge is an error and packs as an edge.
    nb = '{32'd31, 32'd32};
    w  = '{32'd33, 32'd34};
    exp_q.push_back(mk_beat(32'd30, nb, w, 0, 2, 1'b0));
    send_edge(32'd30, 32'd31, 32'd33, 1'b0, 1'b0);
    chk("eerr before", 64'(err), 64'd0);
    send_edge(32'd30, 32'd32, 32'd34, 1'b1, 1'b1);
    chk("eerr set", 64'(err), 64'd1);
    drain("eerr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
